// File: rtl/data_mem_hs_if.sv
// data_mem_hs_if: request/response bundle for the data memory.
//   master : drives req_valid/req_write/req_addr/req_wdata/req_be,
//            observes req_ready, rsp_valid/rsp_data/rsp_err, fill_done
//   slave  : the memory side of the same signals
interface data_mem_hs_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_data;
  logic                  rsp_err;
  logic                  fill_done;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_data, rsp_err, fill_done
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_data, rsp_err, fill_done
  );
endinterface

// File: rtl/data_mem_hs.sv
// data_mem_hs: single-port, word-addressed data memory with a valid/ready
// request handshake, per-byte write enables, a one-cycle registered read
// response and a fill sequence that runs after every reset.
//
// Ports:
//   clk  - clock, all logic on posedge
//   rst  - synchronous active-high reset; restarts the fill
//   bus  - data_mem_hs_if.slave: req_valid/req_ready/req_write/req_addr/
//          req_wdata/req_be in, rsp_valid/rsp_data/rsp_err/fill_done out
//
// Optional build macro DATA_MEM_PARITY_EN: stores one even-parity bit per
// byte (array par_mem, flippable hierarchically for error injection) and
// reports a mismatch on rsp_err. Without it rsp_err is tied to 0.
module data_mem_hs #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 16,
  parameter int FILL_MODE = 1
) (
  input  logic          clk,
  input  logic          rst,
  data_mem_hs_if.slave  bus
);
  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {FILL, IDLE} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   fill_cnt;
  logic                ready_r;
  logic                fill_done_r;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                acc_p0;
  logic                acc_wr_p0;
  logic                acc_rd_p0;
  logic                vld_p1;
  logic [DATA_W-1:0]   data_p1;
  logic                err_p1;

  function automatic logic [DATA_W-1:0] fill_pattern(input logic [ADDR_W-1:0] idx);
    logic [DATA_W-1:0] w;
    w = '0;
    if (FILL_MODE != 0) begin
      for (int b = 0; b < DATA_W && b < ADDR_W; b++) w[b] = idx[b];
    end
    return w;
  endfunction

  // ---- stage p0: request acceptance ----
  // req_ready is registered and only high in IDLE, so no accept can happen
  // during the fill; rst masks the accept on the reset edge itself.
  assign acc_p0    = bus.req_valid & ready_r & ~rst;
  assign acc_wr_p0 = acc_p0 & bus.req_write;
  assign acc_rd_p0 = acc_p0 & ~bus.req_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      fill_cnt    <= '0;
      ready_r     <= 1'b0;
      fill_done_r <= 1'b0;
      vld_p1      <= 1'b0;
    end else begin
      vld_p1 <= acc_rd_p0;
      case (state)
        FILL: begin
          fill_cnt <= fill_cnt + 1'b1;
          if (fill_cnt == '1) begin
            state       <= IDLE;
            ready_r     <= 1'b1;
            fill_done_r <= 1'b1;
          end
        end
        IDLE: ;
        default: state <= FILL;
      endcase
    end
  end

  // Storage is updated at accept, so a read on the following cycle sees it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == FILL) begin
        mem[fill_cnt] <= fill_pattern(fill_cnt);
      end else if (acc_wr_p0) begin
        for (int k = 0; k < NB; k++) begin
          if (bus.req_be[k]) mem[bus.req_addr][8*k +: 8] <= bus.req_wdata[8*k +: 8];
        end
      end
    end
  end

  // ---- stage p1: registered read response ----
  always_ff @(posedge clk) begin
    if (rst)            data_p1 <= '0;
    else if (acc_rd_p0) data_p1 <= mem[bus.req_addr];
  end

`ifdef DATA_MEM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];

  function automatic logic [NB-1:0] byte_parity(input logic [DATA_W-1:0] w);
    logic [NB-1:0] p;
    for (int k = 0; k < NB; k++) p[k] = ^w[8*k +: 8];
    return p;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == FILL) begin
        par_mem[fill_cnt] <= byte_parity(fill_pattern(fill_cnt));
      end else if (acc_wr_p0) begin
        for (int k = 0; k < NB; k++) begin
          if (bus.req_be[k]) par_mem[bus.req_addr][k] <= ^bus.req_wdata[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            err_p1 <= 1'b0;
    else if (acc_rd_p0) err_p1 <= |(par_mem[bus.req_addr] ^ byte_parity(mem[bus.req_addr]));
    else                err_p1 <= 1'b0;
  end
`else
  assign err_p1 = 1'b0;
`endif

  assign bus.req_ready = ready_r;
  assign bus.fill_done = fill_done_r;
  assign bus.rsp_valid = vld_p1;
  assign bus.rsp_data  = data_p1;
  assign bus.rsp_err   = err_p1;
endmodule

// File: tb/tb_data_mem_hs.sv
module tb_data_mem_hs;
  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  data_mem_hs_if #(.DATA_W(32), .ADDR_W(4)) bus ();

  data_mem_hs #(.DATA_W(32), .ADDR_W(4), .FILL_MODE(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: plain word array plus the expected response state.
  logic [31:0] model [16];
  bit          mdl_ready;
  logic        exp_valid;
  logic [31:0] exp_data;

  task automatic reset_model();
    for (int i = 0; i < 16; i++) model[i] = 32'(i);
    mdl_ready = 0;
    exp_valid = 0;
    exp_data  = '0;
  endtask

  // Called at a negedge; hold rst for n posedges, release at the next negedge.
  task automatic reset_pulse(input int n);
    bus.req_valid = 0;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    reset_model();
  endtask

  // One request cycle: drive at negedge, model the accept at posedge,
  // return at the following negedge with outputs ready to sample.
  task automatic step(input bit v, input bit w, input logic [3:0] a,
                      input logic [31:0] d, input logic [3:0] be);
    bus.req_valid = v;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_be    = be;
    @(posedge clk);
    exp_valid = 0;
    if (v && mdl_ready) begin
      if (w) begin
        for (int k = 0; k < 4; k++)
          if (be[k]) model[a][8*k +: 8] = d[8*k +: 8];
      end else begin
        exp_valid = 1;
        exp_data  = model[a];
      end
    end
    @(negedge clk);
    bus.req_valid = 0;
  endtask

  task automatic test_reset();
    reset_pulse(2);
    checks++;
    if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'h0 ||
        bus.rsp_err !== 1'b0 || bus.fill_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b data=%h err=%b done=%b required all 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.fill_done);
    end
    for (int k = 1; k <= 16; k++) begin
      logic e;
      @(posedge clk);
      @(negedge clk);
      e = (k == 16);
      checks++;
      if (bus.req_ready !== e || bus.fill_done !== e) begin
        errors++;
        $display("FAIL fill_len cycle %0d got rdy=%b done=%b required %b", k,
                 bus.req_ready, bus.fill_done, e);
      end
    end
    mdl_ready = 1;
  endtask

  task automatic test_fill_read();
    step(1, 0, 4'd5, '0, '0);
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0000_0005) begin
      errors++;
      $display("FAIL fill_read got vld=%b data=%h required 1 00000005", bus.rsp_valid, bus.rsp_data);
    end
    step(0, 0, '0, '0, '0);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'h0000_0005) begin
      errors++;
      $display("FAIL rsp_hold got vld=%b data=%h required 0 00000005", bus.rsp_valid, bus.rsp_data);
    end
  endtask

  task automatic test_byte_enable();
    step(1, 1, 4'd3, 32'hAABB_CCDD, 4'b0101);
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL be_write_no_rsp got vld=%b required 0", bus.rsp_valid);
    end
    step(1, 1, 4'd3, 32'hFFFF_FFFF, 4'b0000);
    step(1, 0, 4'd3, '0, '0);
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h00BB_00DD) begin
      errors++;
      $display("FAIL byte_enable got vld=%b data=%h required 1 00bb00dd", bus.rsp_valid, bus.rsp_data);
    end
  endtask

  task automatic test_back_to_back();
    logic        ev [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] ed [4] = '{32'h00BB_00DD, 32'h1234_5678, 32'h0000_0006, 32'h0000_0006};
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: step(1, 1, 4'd7, 32'h1234_5678, 4'hF);
        1: step(1, 0, 4'd7, '0, '0);
        2: step(1, 0, 4'd6, '0, '0);
        default: step(0, 0, '0, '0, '0);
      endcase
      checks++;
      if (bus.rsp_valid !== ev[c] || bus.rsp_data !== ed[c]) begin
        errors++;
        $display("FAIL back_to_back cycle %0d got vld=%b data=%h required %b %h", c,
                 bus.rsp_valid, bus.rsp_data, ev[c], ed[c]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
           $urandom, 4'($urandom_range(0, 15)));
      checks++;
      if (bus.rsp_valid !== exp_valid || bus.rsp_data !== exp_data ||
          bus.rsp_err !== 1'b0 || bus.req_ready !== 1'b1) begin
        errors++;
        $display("FAIL random %0d got vld=%b data=%h err=%b rdy=%b required %b %h 0 1", n,
                 bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.req_ready, exp_valid, exp_data);
      end
    end
  endtask

  task automatic test_handshake_during_fill();
    reset_pulse(2);
    bus.req_valid = 1;
    bus.req_write = 1;
    bus.req_addr  = 4'd0;
    bus.req_wdata = 32'hFFFF_FFFF;
    bus.req_be    = 4'hF;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k < 16) begin
        checks++;
        if (bus.req_ready !== 1'b0) begin
          errors++;
          $display("FAIL fill_ready cycle %0d got %b required 0", k, bus.req_ready);
        end
      end
    end
    bus.req_valid = 0;
    mdl_ready = 1;
    step(1, 0, 4'd0, '0, '0);
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL fill_ignores_req got vld=%b data=%h required 1 00000000",
               bus.rsp_valid, bus.rsp_data);
    end
  endtask

  task automatic test_reset_midfill();
    step(1, 1, 4'd9, 32'hDEAD_BEEF, 4'hF);
    step(1, 1, 4'd12, 32'h0BAD_F00D, 4'hF);
    step(1, 0, 4'd9, '0, '0);
    reset_pulse(2);
    checks++;
    if (bus.rsp_data !== 32'h0 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp_clear got vld=%b data=%h required 0 00000000",
               bus.rsp_valid, bus.rsp_data);
    end
    repeat (9) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset_pulse(1);
    for (int k = 1; k <= 16; k++) begin
      logic e;
      @(posedge clk);
      @(negedge clk);
      e = (k == 16);
      checks++;
      if (bus.fill_done !== e || bus.req_ready !== e) begin
        errors++;
        $display("FAIL midfill_len cycle %0d got done=%b rdy=%b required %b", k,
                 bus.fill_done, bus.req_ready, e);
      end
    end
    mdl_ready = 1;
    for (int a = 0; a < 16; a++) begin
      step(1, 0, 4'(a), '0, '0);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'(a)) begin
        errors++;
        $display("FAIL midfill_word %0d got vld=%b data=%h required 1 %h", a,
                 bus.rsp_valid, bus.rsp_data, 32'(a));
      end
    end
  endtask

`ifdef DATA_MEM_PARITY_EN
  task automatic test_parity();
    dut.par_mem[2][0] = ~dut.par_mem[2][0];
    step(1, 0, 4'd2, '0, '0);
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_data !== 32'h2) begin
      errors++;
      $display("FAIL parity_err got vld=%b err=%b data=%h required 1 1 00000002",
               bus.rsp_valid, bus.rsp_err, bus.rsp_data);
    end
    step(1, 0, 4'd4, '0, '0);
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_data !== 32'h4) begin
      errors++;
      $display("FAIL parity_clean got vld=%b err=%b data=%h required 1 0 00000004",
               bus.rsp_valid, bus.rsp_err, bus.rsp_data);
    end
  endtask
`endif

  initial begin
    bus.req_valid = 0;
    bus.req_write = 0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    reset_model();
    @(negedge clk);
    test_reset();
    test_fill_read();
    test_byte_enable();
    test_back_to_back();
    test_random();
    test_handshake_during_fill();
    test_reset_midfill();
`ifdef DATA_MEM_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1);
  end
endmodule

// File: doc/data_mem_hs.md
Name: data_mem_hs

Overview:
- Parametrised, single-port, word-addressed data memory for the datapath. Successor to the fixed 32-bit, 64K-word data memory.
- Adds a valid/ready request handshake, per-byte write enables, a registered read response and a reset-driven fill sequence that replaces simulation-only initialisation.
- Sits between the load/store stage and backing storage. Serves one request per cycle once the fill is complete.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 16, word-address width; DEPTH = 2**ADDR_W words.
- FILL_MODE, 1, reset fill pattern: 0 = zero fill, 1 = mem[i] = i (zero-extended, or truncated to DATA_W).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte enables for writes; bit k covers bits [8k+7:8k].
- rsp_valid  out  1  read data valid (single-cycle pulse).
- rsp_data  out  DATA_W  read data.
- rsp_err  out  1  parity error on this response (0 unless feature enabled).
- fill_done  out  1  fill sequence complete.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- FSM states: FILL, IDLE.
- Reset, sampled high at a posedge:
  - state = FILL, fill counter = 0.
  - req_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_err = 0, fill_done = 0.
  - Reset is honoured in any state, including mid-fill; the fill then restarts from 0.
- FILL:
  - Each cycle writes the full word mem[cnt] = pattern(cnt), then cnt increments.
  - After the write of DEPTH-1, the next state is IDLE and fill_done goes 1 in that same cycle.
  - The fill takes exactly DEPTH cycles after reset deasserts.
  - req_ready = 0 throughout, and req_valid is ignored.
- IDLE:
  - req_ready = 1 continuously; the block has no backpressure after the fill.
  - A request is accepted when req_valid & req_ready at a posedge.
- Write accept:
  - Only enabled bytes are updated.
  - req_be = 0 is a legal no-op.
  - No response is generated.
- Read accept:
  - rsp_data = mem[req_addr] and rsp_valid = 1 in the cycle after acceptance (latency 1).
  - rsp_valid = 0 in any cycle with no read accepted in the previous cycle.
  - rsp_data holds its last value when rsp_valid = 0.
- Back-to-back:
  - Any mix of reads and writes is accepted on consecutive cycles.
  - A read issued the cycle after a write to the same address returns the new data.
  - Reads are not forwarded from in-flight state; memory is updated at accept.
- Address: every ADDR_W value is in range; there is no wrap or error.
- fill_done stays 1 until the next reset.

Optional Feature:
- Macro: DATA_MEM_PARITY_EN.
- Defined:
  - Each byte stores an extra even-parity bit, giving DEPTH x (DATA_W + DATA_W/8) storage.
  - Parity is written on fill and on each enabled-byte write.
  - On a read, recomputed parity is compared with stored parity.
  - rsp_err = 1 alongside rsp_valid if any byte mismatches.
  - rsp_data is returned unmodified.
  - A hierarchical test hook flips a stored parity bit.
- Not defined: no parity storage; rsp_err is tied to 0.

Test Plan:
- Bench config: DATA_W=32, ADDR_W=4, FILL_MODE=1.
- Reset and fill: assert rst for 2 cycles, then release -> req_ready = 0 for exactly 16 cycles, then fill_done = 1, req_ready = 1. Read addr 5 -> rsp_valid one cycle later, rsp_data = 0x00000005.
- Byte-enable write: write addr 3, data 0xAABBCCDD, be = 4'b0101, then read addr 3 -> rsp_data = 0x00BB00DD (original 0x00000003 bytes 1 and 3 preserved).
- Back-to-back: same-cycle stream W(7, 0x12345678, be = F), R(7), R(6) on consecutive cycles -> rsp_valid high on cycles 3 and 4, rsp_data = 0x12345678 then 0x00000006.
- Reset mid-fill: raise rst at fill cycle 9 -> fill restarts; fill_done appears exactly 16 cycles after rst release, and all 16 words read back as their index.
- Handshake during fill: hold req_valid = 1 with a write to addr 0 during the fill -> no acceptance; addr 0 reads 0x00000000 after the fill.
- Parity (macro defined): flip the stored parity bit of byte 0 of addr 2, read addr 2 -> rsp_err = 1, rsp_data = 0x00000002. Read addr 4 -> rsp_err = 0.
